wb_arbiter_3to2: RTL and testbench
==================================

Name: wb_arbiter_3to2

Overview:
- Writeback arbiter sitting directly upstream of the 2-write-port register storage built from 3-read/2-write flip-flop cells.
- Accepts results from three execution sources (ALU0, ALU1, MEM) over valid/ready handshakes.
- Each cycle, grants up to two of them round-robin and drives the register file's two write ports (write1 has priority inside the storage cell) from registered outputs.

Parameters:
- DATA_WIDTH, 32, width of result data and write ports.
- ADDR_WIDTH, 5, width of destination register index; register 0 is hardwired zero.
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- src_valid_i  input  3  per-source result valid; bit 0 = ALU0, bit 1 = ALU1, bit 2 = MEM.
- src_ready_o  output  3  per-source accept; transfer when valid and ready are both high in the same cycle.
- src_addr_i  input  3*ADDR_WIDTH  per-source destination index, source k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- src_data_i  input  3*DATA_WIDTH  per-source result data, same packing.
- wr1_en_o  output  1  write port 1 enable.
- wr1_addr_o  output  ADDR_WIDTH  write port 1 index.
- wr1_data_o  output  DATA_WIDTH  write port 1 data.
- wr2_en_o  output  1  write port 2 enable.
- wr2_addr_o  output  ADDR_WIDTH  write port 2 index.
- wr2_data_o  output  DATA_WIDTH  write port 2 data.
- conflict_cnt_o  output  CNT_WIDTH  saturating count of cycles where at least one valid, non-zero-dest source was refused.

Behaviour:
- Reset: wr1/wr2 en, addr, data = 0; conflict_cnt_o = 0; rr_ptr = 0; src_ready_o = 0 while rst is high.
- Eligible source: valid with dest != 0.
- Zero-dest source: valid with dest == 0. It is always ready, consumes no slot, and produces no write.
- Grant scan, combinational, in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3):
  - The first eligible source gets slot 1.
  - The next eligible source whose dest differs from slot 1's dest gets slot 2.
  - All other eligible sources get ready = 0 and hold.
- Same-dest rule: two eligible sources with equal dest never both win in one cycle. The later one in scan order waits.
- src_ready_o is combinational from src_valid_i, src_addr_i and rr_ptr. Ready for an ungranted source is 0 even when it is invalid.
- Latency: one cycle. A slot granted in cycle N appears on wrX_* in cycle N+1, en = 1, addr/data = the granted source's inputs.
- Ungranted slot: en = 0 the next cycle; addr/data hold their previous values.
- rr_ptr update:
  - If at least one slot is granted: rr_ptr <= (index of last granted source + 1) mod 3.
  - Otherwise rr_ptr is unchanged.
  - Zero-dest acceptances do not move rr_ptr.
- conflict_cnt_o increments by 1 in any cycle with at least one eligible source refused. It saturates at all-ones and never wraps.
- Reset mid-operation: outstanding grants are discarded, with no write in the cycle after reset. Sources must re-present their results.
- Throughput: sustained 2 writes/cycle; with 3 sources always valid, each source wins 2 of every 3 cycles.

Decomposition:
- Shared package wb_pkg holds:
  - constants NUM_SRC = 3 and SRC_ALU0/SRC_ALU1/SRC_MEM = 0/1/2;
  - typedef wb_req_t {addr, data};
  - a function next_idx(idx) returning (idx+1) mod 3.
- One natural sub-module, rr_pick3, is purely combinational: it takes valid/eligible/addr and rr_ptr, and returns the slot1/slot2 one-hot grants and the last-granted index.
- The top module holds the output registers, rr_ptr and the counter.

Test Plan:
- Reset: assert rst 2 cycles with all sources valid -> src_ready_o = 000, wr1_en_o = wr2_en_o = 0, conflict_cnt_o = 0 throughout.
- Dual grant: rr_ptr = 0, ALU0 (addr 3, data 0xA) and ALU1 (addr 7, data 0xB) valid -> ready = 011; next cycle wr1 = (1,3,0xA), wr2 = (1,7,0xB); rr_ptr = 2.
- Three-way fairness: all sources valid with distinct non-zero addrs for 6 cycles from rr_ptr = 0 -> grants {0,1},{2,0},{1,2},{0,1},{2,0},{1,2}; conflict_cnt_o = 6.
- Same dest: ALU0 and ALU1 both addr 5, MEM addr 9, rr_ptr = 0 -> slot1 = ALU0, slot2 = MEM, ALU1 held; ALU1 granted the following cycle; counter +1.
- Zero dest: MEM addr 0 with ALU0 addr 4 valid -> ready = 101; only wr1 = (1,4,data) next cycle; wr2_en_o = 0; rr_ptr = 1.
- Saturation and reset: CNT_WIDTH = 4 with 20 conflict cycles -> conflict_cnt_o stops at 15; then rst for 1 cycle mid-grant -> next-cycle wr enables 0, counter 0, rr_ptr 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: source indices, request type
// and the mod-3 round-robin step.
package wb_pkg;

   localparam int NUM_SRC  = 3;
   localparam int SRC_ALU0 = 0;
   localparam int SRC_ALU1 = 1;
   localparam int SRC_MEM  = 2;

   localparam int WB_ADDR_W = 5;
   localparam int WB_DATA_W = 32;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: up to two grants per cycle from three
// sources, never granting two sources that target the same register.
module rr_pick3
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic [NUM_SRC-1:0]            valid,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0] addr,
   input  logic [1:0]                    rr_ptr,
   output logic [NUM_SRC-1:0]            elig,
   output logic [NUM_SRC-1:0]            gnt1,
   output logic [NUM_SRC-1:0]            gnt2,
   output logic [1:0]                    last_idx
);

   logic [1:0]            idx;
   logic                  have1;
   logic                  have2;
   logic [ADDR_WIDTH-1:0] a1;

   // Writes to register 0 are dropped, so only non-zero destinations compete.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_elig
      assign elig[i] = valid[i] && (addr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0);
   end

   always_comb begin
      gnt1     = '0;
      gnt2     = '0;
      last_idx = rr_ptr;
      have1    = 1'b0;
      have2    = 1'b0;
      a1       = '0;
      idx      = rr_ptr;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (elig[idx]) begin
            if (!have1) begin
               gnt1[idx] = 1'b1;
               a1        = addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
               have1     = 1'b1;
               last_idx  = idx;
            end else if (!have2 && (addr[idx*ADDR_WIDTH +: ADDR_WIDTH] != a1)) begin
               gnt2[idx] = 1'b1;
               have2     = 1'b1;
               last_idx  = idx;
            end
         end
         idx = next_idx(idx);
      end
   end

endmodule

// File: rtl/wb_arbiter_3to2.sv
// Writeback arbiter: three result sources onto the register file's two write
// ports, round-robin, with registered write outputs and a conflict counter.
module wb_arbiter_3to2
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            src_valid_i,
   output logic [NUM_SRC-1:0]            src_ready_o,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
   output logic                          wr1_en_o,
   output logic [ADDR_WIDTH-1:0]         wr1_addr_o,
   output logic [DATA_WIDTH-1:0]         wr1_data_o,
   output logic                          wr2_en_o,
   output logic [ADDR_WIDTH-1:0]         wr2_addr_o,
   output logic [DATA_WIDTH-1:0]         wr2_data_o,
   output logic [CNT_WIDTH-1:0]          conflict_cnt_o
);

   logic [1:0]            rr_ptr;
   logic [NUM_SRC-1:0]    elig;
   logic [NUM_SRC-1:0]    gnt1;
   logic [NUM_SRC-1:0]    gnt2;
   logic [NUM_SRC-1:0]    zero_dst;
   logic [1:0]            last_idx;
   logic                  refused;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [DATA_WIDTH-1:0] s1_data;
   logic [ADDR_WIDTH-1:0] s2_addr;
   logic [DATA_WIDTH-1:0] s2_data;

   rr_pick3 #(.ADDR_WIDTH(ADDR_WIDTH)) u_pick (
      .valid    (src_valid_i),
      .addr     (src_addr_i),
      .rr_ptr   (rr_ptr),
      .elig     (elig),
      .gnt1     (gnt1),
      .gnt2     (gnt2),
      .last_idx (last_idx)
   );

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_zero
      assign zero_dst[i] = src_valid_i[i] &&
                           (src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == '0);
   end

   // Zero-dest results are swallowed without taking a write slot.
   assign src_ready_o = rst ? '0 : (gnt1 | gnt2 | zero_dst);
   assign refused     = |(elig & ~(gnt1 | gnt2));

   always_comb begin
      s1_addr = '0;
      s1_data = '0;
      s2_addr = '0;
      s2_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt1[i]) begin
            s1_addr = src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            s1_data = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
         if (gnt2[i]) begin
            s2_addr = src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            s2_data = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr1_en_o       <= 1'b0;
         wr1_addr_o     <= '0;
         wr1_data_o     <= '0;
         wr2_en_o       <= 1'b0;
         wr2_addr_o     <= '0;
         wr2_data_o     <= '0;
         rr_ptr         <= 2'd0;
         conflict_cnt_o <= '0;
      end else begin
         wr1_en_o <= |gnt1;
         wr2_en_o <= |gnt2;
         if (|gnt1) begin
            wr1_addr_o <= s1_addr;
            wr1_data_o <= s1_data;
         end
         if (|gnt2) begin
            wr2_addr_o <= s2_addr;
            wr2_data_o <= s2_data;
         end
         // Slot 2 is only ever granted alongside slot 1.
         if (|gnt1)
            rr_ptr <= next_idx(last_idx);
         if (refused && (conflict_cnt_o != '1))
            conflict_cnt_o <= conflict_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_arbiter_3to2.sv
// Self-checking bench for wb_arbiter_3to2: vector table plus reset and
// counter-saturation sequences, write outputs checked through a queue.
module tb_wb_arbiter_3to2;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        src_valid_i;
   logic [2:0]        src_ready_o;
   logic [3*AW-1:0]   src_addr_i;
   logic [3*DW-1:0]   src_data_i;
   logic              wr1_en_o, wr2_en_o;
   logic [AW-1:0]     wr1_addr_o, wr2_addr_o;
   logic [DW-1:0]     wr1_data_o, wr2_data_o;
   logic [CW-1:0]     conflict_cnt_o;

   wb_arbiter_3to2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .src_valid_i    (src_valid_i),
      .src_ready_o    (src_ready_o),
      .src_addr_i     (src_addr_i),
      .src_data_i     (src_data_i),
      .wr1_en_o       (wr1_en_o),
      .wr1_addr_o     (wr1_addr_o),
      .wr1_data_o     (wr1_data_o),
      .wr2_en_o       (wr2_en_o),
      .wr2_addr_o     (wr2_addr_o),
      .wr2_data_o     (wr2_data_o),
      .conflict_cnt_o (conflict_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    valid;
      logic [3*AW-1:0] addr;
      logic [3*DW-1:0] data;
      logic [2:0]    rdy;
      logic          e1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          e2;
      logic [AW-1:0] a2;
      logic [DW-1:0] d2;
      logic [CW-1:0] cnt;
   } vec_t;

   typedef struct {
      logic          e1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          e2;
      logic [AW-1:0] a2;
      logic [DW-1:0] d2;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   vec_t          vt[18];
   int            total = 0;
   int            bad   = 0;
   logic [AW-1:0] h_a1, h_a2;
   logic [DW-1:0] h_d1, h_d2;

   function automatic vec_t mk(input logic [2:0] v,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic [2:0] rdy,
                               input logic e1, input logic [AW-1:0] ea1, input logic [DW-1:0] ed1,
                               input logic e2, input logic [AW-1:0] ea2, input logic [DW-1:0] ed2,
                               input logic [CW-1:0] cnt);
      vec_t r;
      r.valid = v;
      r.addr  = {a2, a1, a0};
      r.data  = {d2, d1, d0};
      r.rdy   = rdy;
      r.e1 = e1; r.a1 = ea1; r.d1 = ed1;
      r.e2 = e2; r.a2 = ea2; r.d2 = ed2;
      r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   // Called at posedge+1: drive, check ready, queue expected writes, then
   // compare them one edge later.
   task automatic step(input vec_t v);
      exp_t e, got;
      src_valid_i = v.valid;
      src_addr_i  = v.addr;
      src_data_i  = v.data;
      #1;
      chk("ready", {29'd0, src_ready_o}, {29'd0, v.rdy});
      e.e1 = v.e1; e.e2 = v.e2; e.cnt = v.cnt;
      if (v.e1) begin h_a1 = v.a1; h_d1 = v.d1; end
      if (v.e2) begin h_a2 = v.a2; h_d2 = v.d2; end
      e.a1 = h_a1; e.d1 = h_d1; e.a2 = h_a2; e.d2 = h_d2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         got = sb.pop_front();
         chk("wr1_en",   {31'd0, wr1_en_o}, {31'd0, got.e1});
         chk("wr1_addr", {27'd0, wr1_addr_o}, {27'd0, got.a1});
         chk("wr1_data", wr1_data_o, got.d1);
         chk("wr2_en",   {31'd0, wr2_en_o}, {31'd0, got.e2});
         chk("wr2_addr", {27'd0, wr2_addr_o}, {27'd0, got.a2});
         chk("wr2_data", wr2_data_o, got.d2);
         chk("conflict_cnt", {28'd0, conflict_cnt_o}, {28'd0, got.cnt});
      end
   endtask

   task automatic reset_cycles(input int n);
      rst = 1'b1;
      src_valid_i = 3'b111;
      src_addr_i  = {5'd6, 5'd2, 5'd1};
      src_data_i  = {32'hEE, 32'hDD, 32'hCC};
      for (int i = 0; i < n; i++) begin
         #1;
         chk("rst_ready", {29'd0, src_ready_o}, 32'd0);
         @(posedge clk);
         #1;
         chk("rst_wr1_en", {31'd0, wr1_en_o}, 32'd0);
         chk("rst_wr2_en", {31'd0, wr2_en_o}, 32'd0);
         chk("rst_cnt", {28'd0, conflict_cnt_o}, 32'd0);
      end
      rst = 1'b0;
      h_a1 = '0; h_d1 = '0; h_a2 = '0; h_d2 = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] aa[3];
      logic [DW-1:0] dd[3];
      int            s1, s2;
      logic [CW-1:0] cm;
      int            s1t[3];
      int            s2t[3];

      vt[0]  = mk(3'b011, 3, 7, 0, 32'hA, 32'hB, 0,         3'b011, 1, 3, 32'hA, 1, 7, 32'hB, 0);
      vt[1]  = mk(3'b111, 1, 2, 6, 32'h10, 32'h11, 32'h12, 3'b101, 1, 6, 32'h12, 1, 1, 32'h10, 1);
      vt[2]  = mk(3'b111, 1, 2, 6, 32'h13, 32'h14, 32'h15, 3'b110, 1, 2, 32'h14, 1, 6, 32'h15, 2);
      vt[3]  = mk(3'b111, 1, 2, 6, 32'h20, 32'h21, 32'h22, 3'b011, 1, 1, 32'h20, 1, 2, 32'h21, 3);
      vt[4]  = mk(3'b111, 1, 2, 6, 32'h23, 32'h24, 32'h25, 3'b101, 1, 6, 32'h25, 1, 1, 32'h23, 4);
      vt[5]  = mk(3'b111, 1, 2, 6, 32'h26, 32'h27, 32'h28, 3'b110, 1, 2, 32'h27, 1, 6, 32'h28, 5);
      vt[6]  = mk(3'b111, 1, 2, 6, 32'h29, 32'h2A, 32'h2B, 3'b011, 1, 1, 32'h29, 1, 2, 32'h2A, 6);
      vt[7]  = mk(3'b111, 1, 2, 6, 32'h2C, 32'h2D, 32'h2E, 3'b101, 1, 6, 32'h2E, 1, 1, 32'h2C, 7);
      vt[8]  = mk(3'b111, 1, 2, 6, 32'h2F, 32'h30, 32'h31, 3'b110, 1, 2, 32'h30, 1, 6, 32'h31, 8);
      vt[9]  = mk(3'b111, 5, 5, 9, 32'h40, 32'h41, 32'h42, 3'b101, 1, 5, 32'h40, 1, 9, 32'h42, 9);
      vt[10] = mk(3'b010, 0, 5, 0, 0, 32'h41, 0,           3'b010, 1, 5, 32'h41, 0, 0, 0, 9);
      vt[11] = mk(3'b100, 0, 0, 3, 0, 0, 32'h50,           3'b100, 1, 3, 32'h50, 0, 0, 0, 9);
      vt[12] = mk(3'b101, 4, 0, 0, 32'h60, 0, 32'h61,      3'b101, 1, 4, 32'h60, 0, 0, 0, 9);
      vt[13] = mk(3'b000, 0, 0, 0, 0, 0, 0,                3'b000, 0, 0, 0, 0, 0, 0, 9);
      vt[14] = mk(3'b011, 0, 0, 7, 32'h1, 32'h2, 32'h3,    3'b011, 0, 0, 0, 0, 0, 0, 9);
      vt[15] = mk(3'b111, 1, 2, 6, 32'h70, 32'h71, 32'h72, 3'b110, 1, 2, 32'h71, 1, 6, 32'h72, 10);
      vt[16] = mk(3'b111, 8, 8, 8, 32'h80, 32'h81, 32'h82, 3'b001, 1, 8, 32'h80, 0, 0, 0, 11);
      vt[17] = mk(3'b111, 8, 8, 9, 32'h83, 32'h84, 32'h85, 3'b110, 1, 8, 32'h84, 1, 9, 32'h85, 12);

      rst = 1'b1;
      src_valid_i = 3'b111;
      src_addr_i  = '0;
      src_data_i  = '0;
      @(posedge clk);
      #1;
      reset_cycles(2);

      for (int i = 0; i < 18; i++)
         step(vt[i]);

      // Counter saturation with all three sources continuously presenting.
      reset_cycles(1);
      aa[0] = 5'd1; aa[1] = 5'd2; aa[2] = 5'd6;
      s1t[0] = 0; s1t[1] = 2; s1t[2] = 1;
      s2t[0] = 1; s2t[1] = 0; s2t[2] = 2;
      cm = '0;
      for (int k = 0; k < 20; k++) begin
         for (int j = 0; j < 3; j++)
            dd[j] = 32'h300 + 32'(k * 3 + j);
         s1 = s1t[k % 3];
         s2 = s2t[k % 3];
         cm = (cm == 4'hF) ? 4'hF : cm + 4'd1;
         step(mk(3'b111, aa[0], aa[1], aa[2], dd[0], dd[1], dd[2],
                 3'((1 << s1) | (1 << s2)),
                 1, aa[s1], dd[s1], 1, aa[s2], dd[s2], cm));
      end

      // Reset landing on a cycle that would otherwise grant.
      reset_cycles(1);
      step(mk(3'b111, 1, 2, 6, 32'h90, 32'h91, 32'h92, 3'b011, 1, 1, 32'h90, 1, 2, 32'h91, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
